// File: rtl/t5_dcde_if.sv
// Fetch-to-decode bus: fetched word and PC in, register-file read addresses
// and registered decode controls out.
interface t5_dcde_if #(parameter int XLEN = 32);
  logic            sena;
  logic [31:0]     idat;
  logic [XLEN-1:0] fpc;
  logic [6:0]      radr1;
  logic [6:0]      radr2;
  logic [XLEN-1:0] dpc;
  logic [XLEN-1:0] dimm;
  logic [4:0]      drd;
  logic [2:0]      dfn3;
  logic            dalt;
  logic [3:0]      dcls;
  logic            dwre;
  logic            dval;
  logic            dill;
  logic [3:0]      dhalt;

  modport master (output sena, idat, fpc,
                  input  radr1, radr2, dpc, dimm, drd, dfn3, dalt, dcls,
                         dwre, dval, dill, dhalt);
  modport slave  (input  sena, idat, fpc,
                  output radr1, radr2, dpc, dimm, drd, dfn3, dalt, dcls,
                         dwre, dval, dill, dhalt);
endinterface

// File: rtl/t5_dcde.sv
// Decode stage of the 4-hart barrel pipeline: RV32I decode, hart-banked RF
// read addresses, and a sticky per-hart halt raised by illegal instructions.

// One hart's RUN/HALT tracker; only reset leaves HALT.
module t5_dcde_hart (
  input  logic sclk,
  input  logic srst,
  input  logic sena,
  input  logic hsel,
  input  logic ill,
  output logic halt
);
  typedef enum logic {RUN = 1'b0, HALT = 1'b1} st_e;
  st_e st_q;

  always_ff @(posedge sclk) begin
    if (!srst) begin
      st_q <= RUN;
      halt <= 1'b0;
    end else if (sena) begin
      case (st_q)
        RUN:  if (hsel && ill) begin
                st_q <= HALT;
                halt <= 1'b1;
              end
        HALT: halt <= 1'b1;
        default: begin
          st_q <= RUN;
          halt <= 1'b0;
        end
      endcase
    end
  end
endmodule

module t5_dcde #(
  parameter int XLEN = 32
) (
  input  logic      sclk,
  input  logic      srst,
  t5_dcde_if.slave  bus
);
  typedef enum logic [3:0] {
    C_NOP = 4'd0, C_LUI = 4'd1, C_AUIPC = 4'd2, C_JAL = 4'd3, C_JALR = 4'd4,
    C_BRA = 4'd5, C_LOAD = 4'd6, C_STORE = 4'd7, C_OPIMM = 4'd8, C_OP = 4'd9,
    C_FENCE = 4'd10, C_SYS = 4'd11
  } cls_e;

  logic [31:0] idat;
  logic [1:0]  hart;
  logic [4:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [3:0]  halt_v;
  logic        halted;
  cls_e        cls;
  logic        bad;

  assign idat   = bus.idat;
  assign hart   = bus.fpc[1:0];
  assign opc    = idat[6:2];
  assign f3     = idat[14:12];
  assign f7     = idat[31:25];
  assign halted = halt_v[hart];

  assign bus.radr1 = {hart, idat[19:15]};
  assign bus.radr2 = {hart, idat[24:20]};

  // Raw class and legality, before the hart's halt state is applied.
  always_comb begin
    cls = C_NOP;
    bad = 1'b0;
    case (opc)
      5'b01101: cls = C_LUI;
      5'b00101: cls = C_AUIPC;
      5'b11011: cls = C_JAL;
      5'b11001: begin cls = C_JALR;  bad = (f3 != 3'd0); end
      5'b11000: begin cls = C_BRA;   bad = (f3 == 3'd2) || (f3 == 3'd3); end
      5'b00000: begin cls = C_LOAD;  bad = (f3 == 3'd3) || (f3 >= 3'd6); end
      5'b01000: begin cls = C_STORE; bad = (f3 > 3'd2); end
      5'b00100: begin
        cls = C_OPIMM;
        if (f3 == 3'd1)      bad = (f7 != 7'h00);
        else if (f3 == 3'd5) bad = (f7 != 7'h00) && (f7 != 7'h20);
      end
      5'b01100: begin
        cls = C_OP;
        bad = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
      end
      5'b00011: cls = C_FENCE;
      5'b11100: cls = C_SYS;
      default:  bad = 1'b1;
    endcase
    if (idat[1:0] != 2'b11) bad = 1'b1;
  end

  for (genvar h = 0; h < 4; h++) begin : g_hart
    t5_dcde_hart u_hart (
      .sclk (sclk),
      .srst (srst),
      .sena (bus.sena),
      .hsel (hart == 2'(h)),
      .ill  (bad),
      .halt (halt_v[h])
    );
  end

  logic [XLEN-1:0] dpc_d, dpc_q, dimm_d, dimm_q;
  logic [4:0]      drd_d, drd_q;
  logic [2:0]      dfn3_d, dfn3_q;
  logic            dalt_d, dalt_q, dwre_d, dwre_q, dval_d, dval_q, dill_d, dill_q;
  cls_e            dcls_d, dcls_q;
  logic signed [31:0] imm_s;
  logic            wr_cls;

  always_comb begin
    dpc_d  = bus.fpc;
    drd_d  = idat[11:7];
    dfn3_d = f3;
    dalt_d = idat[30];
    dval_d = !halted;
    dill_d = !halted && bad;
    dcls_d = (halted || bad) ? C_NOP : cls;
    // Immediate follows the final class, so bubbles and illegals carry zero.
    case (dcls_d)
      C_LOAD, C_OPIMM, C_JALR, C_SYS:
        imm_s = {{20{idat[31]}}, idat[31:20]};
      C_STORE: imm_s = {{20{idat[31]}}, idat[31:25], idat[11:7]};
      C_BRA:   imm_s = {{19{idat[31]}}, idat[31], idat[7], idat[30:25], idat[11:8], 1'b0};
      C_LUI, C_AUIPC: imm_s = {idat[31:12], 12'h000};
      C_JAL:   imm_s = {{11{idat[31]}}, idat[31], idat[19:12], idat[20], idat[30:21], 1'b0};
      default: imm_s = '0;
    endcase
    dimm_d = XLEN'(imm_s);
    case (dcls_d)
      C_LUI, C_AUIPC, C_JAL, C_JALR, C_LOAD, C_OPIMM, C_OP, C_SYS: wr_cls = 1'b1;
      default: wr_cls = 1'b0;
    endcase
    dwre_d = wr_cls && (drd_d != 5'd0) && dval_d && !dill_d;
  end

  always_ff @(posedge sclk) begin
    if (!srst) begin
      dpc_q  <= '0;
      dimm_q <= '0;
      drd_q  <= '0;
      dfn3_q <= '0;
      dalt_q <= 1'b0;
      dcls_q <= C_NOP;
      dwre_q <= 1'b0;
      dval_q <= 1'b0;
      dill_q <= 1'b0;
    end else if (bus.sena) begin
      dpc_q  <= dpc_d;
      dimm_q <= dimm_d;
      drd_q  <= drd_d;
      dfn3_q <= dfn3_d;
      dalt_q <= dalt_d;
      dcls_q <= dcls_d;
      dwre_q <= dwre_d;
      dval_q <= dval_d;
      dill_q <= dill_d;
    end
  end

  assign bus.dpc   = dpc_q;
  assign bus.dimm  = dimm_q;
  assign bus.drd   = drd_q;
  assign bus.dfn3  = dfn3_q;
  assign bus.dalt  = dalt_q;
  assign bus.dcls  = dcls_q;
  assign bus.dwre  = dwre_q;
  assign bus.dval  = dval_q;
  assign bus.dill  = dill_q;
  assign bus.dhalt = halt_v;
endmodule
